// File: rtl/io_bank_shadow_cfg.sv
// rtl/io_bank_shadow_cfg.sv - multi-pad I/O bank with shadowed config chain and counted commit
// Shadow chain loads serially; a commit accepted only on an exact-length load copies it to the active set.
module io_bank_shadow_cfg #(
  parameter int NUM_PADS = 4
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                isol_n,
  input  logic                ccff_head,
  input  logic                cfg_shift_en,
  input  logic                cfg_commit,
  output logic                ccff_tail,
  output logic                cfg_committed,
  output logic                cfg_error,
  input  logic [NUM_PADS-1:0] gfpga_pad_io_soc_in,
  output logic [NUM_PADS-1:0] gfpga_pad_io_soc_out,
  output logic [NUM_PADS-1:0] gfpga_pad_io_soc_dir,
  input  logic [NUM_PADS-1:0] iopad_outpad,
  output logic [NUM_PADS-1:0] iopad_inpad
);

  localparam int CFG_BITS = 3;
  localparam int TOTAL    = NUM_PADS * CFG_BITS;
  localparam int CW       = $clog2(TOTAL + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(TOTAL);
  localparam logic [CW-1:0] CNT_SAT  = CW'(TOTAL + 1);

  logic [TOTAL-1:0] shadow;
  logic [TOTAL-1:0] active;
  logic [CW-1:0]    bit_cnt;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      shadow        <= '0;
      active        <= '0;
      bit_cnt       <= '0;
      cfg_committed <= 1'b0;
      cfg_error     <= 1'b0;
    end else begin
      cfg_committed <= 1'b0;
      if (cfg_shift_en) begin
        shadow <= {shadow[TOTAL-2:0], ccff_head};
        // Saturating one past full lets an over-long load be told apart from an exact one.
        if (bit_cnt != CNT_SAT) begin
          bit_cnt <= bit_cnt + CW'(1);
        end
        if (cfg_commit) begin
          cfg_error <= 1'b1;
        end
      end else if (cfg_commit) begin
        if (bit_cnt == CNT_FULL) begin
          active        <= shadow;
          bit_cnt       <= '0;
          cfg_committed <= 1'b1;
        end else begin
          cfg_error <= 1'b1;
        end
      end
    end
  end

  assign ccff_tail = shadow[TOTAL-1];

  // Per pad: bit0 DIR, bit1 INV_OUT, bit2 INV_IN; isolation gates everything toward both sides.
  always_comb begin
    gfpga_pad_io_soc_dir = '0;
    gfpga_pad_io_soc_out = '0;
    iopad_inpad          = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      gfpga_pad_io_soc_dir[p] = active[p*CFG_BITS] & isol_n;
      gfpga_pad_io_soc_out[p] = (iopad_outpad[p] ^ active[p*CFG_BITS+1])
                                & active[p*CFG_BITS] & isol_n;
      iopad_inpad[p]          = (gfpga_pad_io_soc_in[p] ^ active[p*CFG_BITS+2])
                                & ~active[p*CFG_BITS] & isol_n;
    end
  end

endmodule
